// File: rtl/ysyx_23060208_pkg.sv
// Shared types and constants for the ysyx_23060208 instruction fetch unit.
package ysyx_23060208_pkg;

    typedef enum logic [1:0] {
        FETCH_REQ   = 2'd0,
        FETCH_WAIT  = 2'd1,
        FETCH_DRAIN = 2'd2
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam int unsigned INST_BYTES       = 4;

endpackage

// File: rtl/ysyx_23060208_ifu_fetch_if.sv
// Fetch-unit bus bundle: redirect input, instruction memory request/response, and IDU handshake.
interface ysyx_23060208_ifu_fetch_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                    exu_nextpc_taken;
    logic [DATA_WIDTH-1:0]   exu_nextpc;
    logic                    imem_req_valid;
    logic                    imem_req_ready;
    logic [DATA_WIDTH-1:0]   imem_req_addr;
    logic                    imem_rsp_valid;
    logic [DATA_WIDTH-1:0]   imem_rsp_data;
    logic                    ifu_to_idu_valid;
    logic [2*DATA_WIDTH-1:0] ifu_to_idu_data_o;
    logic                    idu_to_ifu_ready;

    // The fetch unit itself.
    modport master (
        input  exu_nextpc, exu_nextpc_taken,
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output ifu_to_idu_valid, ifu_to_idu_data_o,
        input  idu_to_ifu_ready
    );

    // Everything around it: EXU, instruction memory and IDU.
    modport slave (
        output exu_nextpc, exu_nextpc_taken,
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  ifu_to_idu_valid, ifu_to_idu_data_o,
        output idu_to_ifu_ready
    );
endinterface

// File: rtl/ysyx_23060208_fifo.sv
// Synchronous FIFO with flush; pointers carry one extra wrap bit so full and empty are distinct.
module ysyx_23060208_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign count_o = wr_ptr_q - rd_ptr_q;
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (count_o == (AW+1)'(DEPTH));
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // NOTE: storage has no reset; a slot is only observable after the write pointer has passed it.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/ysyx_23060208_ifu_fetch.sv
// Instruction fetch unit: one outstanding memory request, redirect handling, and an instruction buffer.
module ysyx_23060208_ifu_fetch
    import ysyx_23060208_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(RESET_PC_DEFAULT),
    parameter int unsigned           FIFO_DEPTH = 4
) (
    input logic                       clk,
    input logic                       rst,
    ysyx_23060208_ifu_fetch_if.master bus
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e            state_q;
    logic [DATA_WIDTH-1:0]   pc_q, inflight_pc_q;
    logic                    redirect, req_ok, req_hs;
    logic                    fifo_push, fifo_full, fifo_empty;
    logic [CW-1:0]           fifo_count;
    logic [2*DATA_WIDTH-1:0] fifo_rdata;

    assign redirect = bus.exu_nextpc_taken;
    // Space is reserved at issue time, so the response push in WAIT can never overflow.
    assign req_ok   = (state_q == FETCH_REQ) && (fifo_count < CW'(FIFO_DEPTH));
    assign req_hs   = req_ok && bus.imem_req_ready;

    // REQ is also the reset state, so the request is masked while reset is held.
    assign bus.imem_req_valid    = req_ok && rst;
    assign bus.imem_req_addr     = pc_q;
    assign bus.ifu_to_idu_valid  = !fifo_empty;
    assign bus.ifu_to_idu_data_o = fifo_empty ? '0 : fifo_rdata;

    assign fifo_push = (state_q == FETCH_WAIT) && bus.imem_rsp_valid && !redirect && !fifo_full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= FETCH_REQ;
            pc_q          <= RESET_PC;
            inflight_pc_q <= '0;
        end else begin
            case (state_q)
                FETCH_REQ: begin
                    if (req_hs) begin
                        inflight_pc_q <= pc_q;
                        pc_q          <= pc_q + DATA_WIDTH'(INST_BYTES);
                        state_q       <= redirect ? FETCH_DRAIN : FETCH_WAIT;
                    end
                end
                FETCH_WAIT: begin
                    if (bus.imem_rsp_valid) state_q <= FETCH_REQ;
                    else if (redirect)      state_q <= FETCH_DRAIN;
                end
                FETCH_DRAIN: begin
                    if (bus.imem_rsp_valid) state_q <= FETCH_REQ;
                end
                default: state_q <= FETCH_REQ;
            endcase
            // NOTE: non-blocking assignments let this later write override the increment above.
            if (redirect) pc_q <= bus.exu_nextpc;
        end
    end

    ysyx_23060208_fifo #(
        .WIDTH (2*DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .push_i  (fifo_push),
        .pop_i   (bus.idu_to_ifu_ready),
        .flush_i (redirect),
        .wdata_i ({inflight_pc_q, bus.imem_rsp_data}),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

endmodule

// File: tb/tb_ysyx_23060208_ifu_fetch.sv
// Randomized bench for the fetch unit against a transaction-level queue model of the fetch stream.
module tb_ysyx_23060208_ifu_fetch;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] START_PC = 32'h8000_0000;

    typedef enum {F_NONE, F_ANY, F_WAIT, F_HS} force_e;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ysyx_23060208_ifu_fetch_if #(.DATA_WIDTH(32)) bus();

    ysyx_23060208_ifu_fetch #(
        .DATA_WIDTH (32),
        .RESET_PC   (START_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model: instructions delivered to the IDU in program order per fetch stream.
    logic [63:0] model_q[$];
    bit          model_out, model_stale, last_redir;
    logic [31:0] model_pc, model_inflight;

    // Memory: a single pending response after a programmable delay.
    bit          mem_pending;
    int unsigned mem_wait;
    logic [31:0] mem_addr;

    int unsigned ready_pct, idu_pct, redir_pct, wait_min, wait_max;
    force_e      force_mode;
    logic [31:0] force_tgt, force_at;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drive_idle();
        bus.exu_nextpc_taken = 1'b0;
        bus.exu_nextpc       = '0;
        bus.imem_req_ready   = 1'b0;
        bus.imem_rsp_valid   = 1'b0;
        bus.imem_rsp_data    = '0;
        bus.idu_to_ifu_ready = 1'b0;
    endtask

    // Called at a falling edge; leaves reset released at a falling edge.
    task automatic do_reset();
        rst = 1'b0;
        drive_idle();
        #1;
        check("rst_req_valid", 64'(bus.imem_req_valid), 64'(0));
        check("rst_idu_valid", 64'(bus.ifu_to_idu_valid), 64'(0));
        check("rst_idu_data",  bus.ifu_to_idu_data_o, 64'(0));
        model_q.delete();
        model_out   = 1'b0;
        model_stale = 1'b0;
        model_pc    = START_PC;
        last_redir  = 1'b0;
        // A request dropped by reset still gets answered: the response must be ignored.
        if (mem_pending) mem_wait = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // One clock cycle: check outputs, choose inputs, advance the model, move to the next falling edge.
    task automatic step();
        logic        exp_rv, rsp_v, rdy, redir, iready, hs, pop;
        logic [31:0] tgt;
        #1;
        exp_rv = !model_out && (model_q.size() < DEPTH);
        check("req_valid", 64'(bus.imem_req_valid), 64'(exp_rv));
        if (exp_rv) check("req_addr", 64'(bus.imem_req_addr), 64'(model_pc));
        check("idu_valid", 64'(bus.ifu_to_idu_valid), 64'(model_q.size() != 0));
        check("idu_data", bus.ifu_to_idu_data_o, (model_q.size() != 0) ? model_q[0] : 64'(0));

        rsp_v  = mem_pending && (mem_wait == 0);
        rdy    = !mem_pending && ($urandom_range(99) < ready_pct);
        iready = ($urandom_range(99) < idu_pct);
        tgt    = $urandom;
        tgt[1:0] = 2'b00;
        redir  = 1'b0;
        if (!last_redir) begin
            case (force_mode)
                F_ANY:   redir = 1'b1;
                F_WAIT:  redir = model_out && !rsp_v;
                F_HS:    redir = exp_rv && rdy && (model_pc == force_at);
                default: redir = ($urandom_range(99) < redir_pct);
            endcase
            if (redir && force_mode != F_NONE) begin
                tgt        = force_tgt;
                force_mode = F_NONE;
            end
        end

        bus.imem_req_ready   = rdy;
        bus.imem_rsp_valid   = rsp_v;
        bus.imem_rsp_data    = rsp_v ? mem_fn(mem_addr) : 32'($urandom);
        bus.exu_nextpc_taken = redir;
        bus.exu_nextpc       = redir ? tgt : 32'($urandom);
        bus.idu_to_ifu_ready = iready;

        hs  = exp_rv && rdy;
        pop = (model_q.size() != 0) && iready && !redir;
        if (pop) void'(model_q.pop_front());
        if (rsp_v && model_out) begin
            if (!model_stale && !redir) model_q.push_back({model_inflight, mem_fn(model_inflight)});
            model_out = 1'b0;
        end
        if (redir) model_q.delete();
        if (redir && model_out) model_stale = 1'b1;
        if (hs) begin
            model_out      = 1'b1;
            model_stale    = redir;
            model_inflight = model_pc;
        end
        if (redir)   model_pc = tgt;
        else if (hs) model_pc = model_pc + 32'd4;

        if (rsp_v) mem_pending = 1'b0;
        if (hs) begin
            mem_pending = 1'b1;
            mem_addr    = bus.imem_req_addr;
            mem_wait    = $urandom_range(wait_max, wait_min);
        end else if (mem_pending && mem_wait != 0) begin
            mem_wait--;
        end
        last_redir = redir;
        @(negedge clk);
    endtask

    task automatic set_mode(input int unsigned rdy, input int unsigned wmin, input int unsigned wmax,
                            input int unsigned idu, input int unsigned rdr);
        ready_pct = rdy;
        wait_min  = wmin;
        wait_max  = wmax;
        idu_pct   = idu;
        redir_pct = rdr;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not end, time %0t limit %0d", $time, 1_000_000);
        $fatal(1);
    end

    initial begin
        drive_idle();
        mem_pending = 1'b0;
        mem_wait    = 0;
        mem_addr    = '0;
        force_mode  = F_NONE;
        force_tgt   = '0;
        force_at    = '0;
        @(negedge clk);
        do_reset();

        // Streaming: one instruction every two cycles, one-cycle memory latency.
        set_mode(100, 0, 0, 100, 0);
        repeat (20) step();

        // Back-pressure: buffer fills to DEPTH, requests stop, then drains without loss.
        set_mode(100, 0, 0, 0, 0);
        repeat (16) step();
        set_mode(100, 0, 0, 100, 0);
        repeat (12) step();

        // Redirect while waiting on a slow response.
        set_mode(100, 3, 3, 100, 0);
        force_mode = F_WAIT;
        force_tgt  = 32'h8000_0100;
        repeat (16) step();

        // Redirect coincident with the handshake for 80000008.
        do_reset();
        set_mode(100, 0, 0, 0, 0);
        force_mode = F_HS;
        force_at   = 32'h8000_0008;
        force_tgt  = 32'h8000_0040;
        repeat (10) step();
        set_mode(100, 0, 0, 100, 0);
        repeat (8) step();

        // Address wrap past the top of the address space.
        force_mode = F_ANY;
        force_tgt  = 32'hFFFF_FFF8;
        repeat (12) step();

        // Reset while waiting with three entries buffered.
        do_reset();
        set_mode(100, 0, 0, 0, 0);
        for (int i = 0; i < 40; i++) begin
            if (model_q.size() == 3 && model_out) break;
            step();
        end
        do_reset();
        set_mode(100, 0, 0, 100, 0);
        repeat (10) step();

        // Random traffic with occasional resets.
        set_mode(70, 0, 3, 60, 5);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(499) == 0) do_reset();
            else step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ysyx_23060208_ifu_fetch.md
YSYX_23060208_IFU_FETCH -- requirements
Module: ysyx_23060208_ifu_fetch

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning PC and instruction width.
REQ-002 SHALL have parameter RESET_PC, default 32'h8000_0000, meaning first fetch address.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning instruction buffer entries; power of two, >=2.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous assert, active-low.
REQ-006 exu_nextpc  input  DATA_WIDTH  redirect target.
REQ-007 exu_nextpc_taken  input  1  redirect strobe, one-cycle pulse.
REQ-008 imem_req_valid  output  1  fetch request valid.
REQ-009 imem_req_ready  input  1  memory accepts request.
REQ-010 imem_req_addr  output  DATA_WIDTH  fetch address.
REQ-011 imem_rsp_valid  input  1  response valid; never in the cycle of its request handshake.
REQ-012 imem_rsp_data  input  DATA_WIDTH  fetched instruction.
REQ-013 ifu_to_idu_valid  output  1  buffer head valid.
REQ-014 ifu_to_idu_data_o  output  2*DATA_WIDTH  {pc, inst} of buffer head.
REQ-015 idu_to_ifu_ready  input  1  IDU accepts head.

Function
REQ-016 SHALL keep at most one memory request outstanding.
REQ-017 SHALL implement states REQ, WAIT, DRAIN.
REQ-018 REQ: imem_req_valid = (fifo_count + 0) < FIFO_DEPTH; imem_req_addr = pc_r.
REQ-019 REQ, handshake, no redirect -> WAIT; inflight_pc <= pc_r; pc_r <= pc_r + 4 (mod 2^DATA_WIDTH, wrap silently).
REQ-020 WAIT, imem_rsp_valid, no redirect -> push {inflight_pc, imem_rsp_data}; -> REQ.
REQ-021 Buffer space SHALL be checked at request issue; push in WAIT never overflows.
REQ-022 Redirect in any state: pc_r <= exu_nextpc; FIFO flushed same edge; pop that cycle ignored.
REQ-023 Redirect in REQ with no handshake -> stay REQ; next request uses new pc_r.
REQ-024 Redirect in REQ coincident with handshake -> DRAIN (accepted request is stale).
REQ-025 Redirect in WAIT with imem_rsp_valid same cycle -> response discarded, -> REQ.
REQ-026 Redirect in WAIT without response -> DRAIN.
REQ-027 DRAIN: imem_req_valid=0; on imem_rsp_valid discard data -> REQ; further redirects update pc_r, stay DRAIN.
REQ-028 ifu_to_idu_valid = FIFO non-empty; data = head entry; pop on valid & idu_to_ifu_ready.
REQ-029 Simultaneous push and pop SHALL both occur; count unchanged.
REQ-030 imem_req_addr SHALL only change while imem_req_valid=1 on redirect.
REQ-031 Latency: request handshake at cycle N, response N+1 -> ifu_to_idu_valid at N+2.

Reset
REQ-032 While rst=0: state=REQ, pc_r=RESET_PC, FIFO empty, imem_req_valid=0, ifu_to_idu_valid=0, ifu_to_idu_data_o=0.
REQ-033 First request SHALL be asserted in the first cycle after rst deasserts.
REQ-034 Reset mid-operation SHALL drop the outstanding request and all buffered entries; responses after reset release while in REQ SHALL be ignored.

Structure
REQ-035 State encoding and RESET_PC default SHALL live in shared package ysyx_23060208_pkg.
REQ-036 Buffer SHALL be sub-module ysyx_23060208_fifo (params WIDTH, DEPTH; push, pop, flush, full, empty, count).
REQ-037 Pointers SHALL be log2(FIFO_DEPTH)+1 bits, wrap naturally.

Verification
REQ-038 Reset release, ready=1, rsp one cycle later, IDU ready=1 -> heads {80000000,i0},{80000004,i1} one per 2 cycles.
REQ-039 IDU ready=0, memory always responding -> exactly 4 entries buffered, imem_req_valid=0 after 4th, no loss on ready=1.
REQ-040 Redirect to 80000100 while WAIT, rsp 3 cycles later -> DRAIN, stale rsp discarded, next req addr 80000100, first head pc 80000100.
REQ-041 Redirect coincident with handshake at 80000008 -> DRAIN; FIFO empty; 80000008 data never reaches IDU.
REQ-042 pc_r=FFFFFFFC (DATA_WIDTH=32) fetch -> next req addr 00000000.
REQ-043 rst pulled low in WAIT with 3 entries buffered -> all outputs 0 immediately; refetch from 80000000.
